// File: rtl/cpu_pkg.sv
// Shared definitions for the memory port arbiter.
//   state_t   : arbiter FSM encoding (IDLE / ISSUE / WAIT)
//   req_id_t  : requester identifiers (loader, dmem, ifetch)
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ID_LD = 2'd0,
    ID_DM = 2'd1,
    ID_IF = 2'd2
  } req_id_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory-macro signals around the
// memory port arbiter.
//   master : requester/memory side (drives reqs and mem_rdata)
//   slave  : arbiter side (drives acks, rdata, memory controls, busy)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport master (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata,
    output ld_req, ld_addr, ld_wdata,
    input  ld_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

  modport slave (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ack, dm_rdata,
    input  ld_req, ld_addr, ld_wdata,
    output ld_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

endinterface

// File: rtl/arb_priority_sel.sv
// Combinational winner select for the memory port arbiter.
// Ports:
//   ld_req, dm_req, if_req : pending requests
//   starved                : ifetch has lost enough arbitrations to outrank dmem
//   gnt_valid              : at least one request pending
//   gnt_id                 : winning requester (meaningful when gnt_valid)
module arb_priority_sel
  import cpu_pkg::*;
(
  input  logic    ld_req,
  input  logic    dm_req,
  input  logic    if_req,
  input  logic    starved,
  output logic    gnt_valid,
  output req_id_t gnt_id
);

  always_comb begin
    gnt_valid = ld_req | dm_req | if_req;
    gnt_id    = ID_LD;
    if (ld_req) begin
      gnt_id = ID_LD;
    end else if (if_req && (starved || !dm_req)) begin
      // a starved ifetch jumps ahead of dmem, never ahead of the loader
      gnt_id = ID_IF;
    end else if (dm_req) begin
      gnt_id = ID_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port instruction/data RAM between the UART loader,
// the dmem stage and instruction fetch. Fixed priority loader > dmem >
// ifetch, with a starvation guard that lets ifetch beat dmem.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : requester handshakes, memory-macro signals and busy
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no transaction; arbitrate and register winner/addr/data
// ISSUE | mem_en high for one cycle; writes ack here
// WAIT  | read latency countdown; ack with mem_rdata at zero
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  state_t            state, state_nxt;
  req_id_t           win_id;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [LAT_W-1:0]  lat_cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic              starved;
  logic              sel_valid;
  req_id_t           sel_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              grant;
  logic              ack_any;
  logic              ack_ok;
  logic              read_done;
  logic              if_deliver;
  logic              dm_deliver;

  assign starved = (starve_cnt >= SC_W'(STARVE_MAX));

  arb_priority_sel u_sel (
    .ld_req    (bus.ld_req),
    .dm_req    (bus.dm_req),
    .if_req    (bus.if_req),
    .starved   (starved),
    .gnt_valid (sel_valid),
    .gnt_id    (sel_id)
  );

  always_comb begin
    sel_addr  = bus.if_addr;
    sel_wdata = '0;
    sel_we    = 1'b0;
    case (sel_id)
      ID_LD: begin
        sel_addr  = bus.ld_addr;
        sel_wdata = bus.ld_wdata;
        sel_we    = 1'b1;
      end
      ID_DM: begin
        sel_addr  = bus.dm_addr;
        sel_wdata = bus.dm_wdata;
        sel_we    = bus.dm_we;
      end
      default: ;
    endcase
  end

  assign grant = (state == IDLE) && sel_valid;

  always_comb begin
    state_nxt = state;
    ack_any   = 1'b0;
    case (state)
      IDLE: begin
        if (sel_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (we_q) begin
          ack_any   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          ack_any   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset is synchronous, but an ack must never show for a transaction
  // that the coming edge aborts, so completions are qualified by reset.
  assign ack_ok     = ack_any & reset;
  assign read_done  = ack_ok & (state == WAIT);
  assign if_deliver = read_done & (win_id == ID_IF);
  assign dm_deliver = read_done & (win_id == ID_DM);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      win_id     <= ID_LD;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state <= state_nxt;

      if (grant) begin
        win_id  <= sel_id;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        we_q    <= sel_we;
        if (sel_id == ID_IF) begin
          starve_cnt <= '0;
        end else if (bus.if_req && !starved) begin
          starve_cnt <= starve_cnt + SC_W'(1);
        end
      end

      if (state == ISSUE) begin
        lat_cnt <= LAT_W'(RD_LAT - 1);
      end else if ((state == WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end

      if (if_deliver) if_rdata_q <= bus.mem_rdata;
      if (dm_deliver) dm_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_en    = (state == ISSUE) & reset;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.ld_ack = ack_ok & (win_id == ID_LD);
  assign bus.dm_ack = ack_ok & (win_id == ID_DM);
  assign bus.if_ack = ack_ok & (win_id == ID_IF);

  // read data passes straight through in the ack cycle, then holds
  assign bus.if_rdata = if_deliver ? bus.mem_rdata : if_rdata_q;
  assign bus.dm_rdata = dm_deliver ? bus.mem_rdata : dm_rdata_q;

  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus ();
  mem_port_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus2 ();

  mem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  mem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .RD_LAT(2), .STARVE_MAX(4)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Unwritten memory locations read back a known address-derived pattern.
  function automatic logic [31:0] pat(input logic [13:0] a);
    if (a == 14'h010) return 32'hDEADBEEF;
    return 32'hC0DE0000 | {18'd0, a};
  endfunction

  // Memory macro models: RD_LAT=1 for dut, RD_LAT=2 for dut2.
  logic [31:0] ram  [0:16383];
  bit          wr   [0:16383];
  logic [31:0] rd1;
  logic [31:0] ram2 [0:15];
  bit          wr2  [0:15];
  logic [31:0] rd2a, rd2b;

  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr] <= bus.mem_wdata;
        wr[bus.mem_addr]  <= 1'b1;
      end else begin
        rd1 <= wr[bus.mem_addr] ? ram[bus.mem_addr] : pat(bus.mem_addr);
      end
    end
  end
  assign bus.mem_rdata = rd1;

  always @(posedge clock) begin
    if (bus2.mem_en) begin
      if (bus2.mem_we) begin
        ram2[bus2.mem_addr[3:0]] <= bus2.mem_wdata;
        wr2[bus2.mem_addr[3:0]]  <= 1'b1;
      end else begin
        rd2a <= wr2[bus2.mem_addr[3:0]] ? ram2[bus2.mem_addr[3:0]] : pat(bus2.mem_addr);
      end
    end
    rd2b <= rd2a;
  end
  assign bus2.mem_rdata = rd2b;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic clear_reqs();
    bus.ld_req = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.if_req = 0; bus.if_addr = '0;
    bus2.ld_req = 0; bus2.ld_addr = '0; bus2.ld_wdata = '0;
    bus2.dm_req = 0; bus2.dm_we = 0; bus2.dm_addr = '0; bus2.dm_wdata = '0;
    bus2.if_req = 0; bus2.if_addr = '0;
  endtask

  // Leaves the bench at posedge+1 with reset released; next cycle is cycle 1.
  task automatic do_reset();
    tick();
    clear_reqs();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    tick();
    reset = 0;
    bus.ld_req = 1; bus.dm_req = 1; bus.if_req = 1;
    bus.ld_addr = 14'h123; bus.ld_wdata = 32'h55;
    tick();
    tick();
    smp();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got=%b exp=0", bus.mem_en); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if ({bus.ld_ack, bus.dm_ack, bus.if_ack} !== 3'b000) begin errors++; $display("FAIL reset_acks got=%b exp=000", {bus.ld_ack, bus.dm_ack, bus.if_ack}); end
    checks++; if (bus.mem_addr !== 14'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata); end
    checks++; if ({bus.if_rdata, bus.dm_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0", bus.if_rdata, bus.dm_rdata); end
    checks++; if (dut.starve_cnt !== 3'd0) begin errors++; $display("FAIL reset_starve got=%0d exp=0", dut.starve_cnt); end
    clear_reqs();
    reset = 1;
  endtask

  task automatic test_if_read();
    do_reset();
    bus.if_req = 1; bus.if_addr = 14'h010;
    smp();
    checks++; if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL ifrd_c1 got en=%b busy=%b exp 0 0", bus.mem_en, bus.busy); end
    tick(); smp();
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 14'h010) begin errors++; $display("FAIL ifrd_issue got en=%b we=%b addr=%h exp 1 0 010", bus.mem_en, bus.mem_we, bus.mem_addr); end
    checks++; if (bus.if_ack !== 1'b0) begin errors++; $display("FAIL ifrd_early_ack got=%b exp=0", bus.if_ack); end
    tick(); smp();
    checks++; if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ifrd_ack got ack=%b data=%h exp 1 deadbeef", bus.if_ack, bus.if_rdata); end
    tick(); bus.if_req = 0; smp();
    checks++; if (bus.if_ack !== 1'b0 || bus.busy !== 1'b0 || bus.if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ifrd_after got ack=%b busy=%b data=%h exp 0 0 deadbeef", bus.if_ack, bus.busy, bus.if_rdata); end
  endtask

  task automatic test_ld_dm_simul();
    do_reset();
    bus.ld_req = 1; bus.ld_addr = 14'h020; bus.ld_wdata = 32'h11;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 14'h030; bus.dm_wdata = 32'h22;
    smp();
    tick(); smp();
    checks++; if (bus.ld_ack !== 1'b1 || bus.dm_ack !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_addr !== 14'h020) begin errors++; $display("FAIL lddm_c2 got ld=%b dm=%b we=%b addr=%h exp 1 0 1 020", bus.ld_ack, bus.dm_ack, bus.mem_we, bus.mem_addr); end
    tick(); bus.ld_req = 0; smp();
    checks++; if (bus.ld_ack !== 1'b0 || bus.dm_ack !== 1'b0) begin errors++; $display("FAIL lddm_c3 got ld=%b dm=%b exp 0 0", bus.ld_ack, bus.dm_ack); end
    tick(); smp();
    checks++; if (bus.dm_ack !== 1'b1 || bus.ld_ack !== 1'b0 || bus.mem_addr !== 14'h030 || bus.mem_wdata !== 32'h22) begin errors++; $display("FAIL lddm_c4 got dm=%b ld=%b addr=%h wd=%h exp 1 0 030 22", bus.dm_ack, bus.ld_ack, bus.mem_addr, bus.mem_wdata); end
    tick(); bus.dm_req = 0; bus.dm_we = 0; smp();
    checks++; if (bus.dm_ack !== 1'b0) begin errors++; $display("FAIL lddm_c5 got dm=%b exp 0", bus.dm_ack); end
    checks++; if (ram[14'h020] !== 32'h11 || ram[14'h030] !== 32'h22) begin errors++; $display("FAIL lddm_mem got %h %h exp 11 22", ram[14'h020], ram[14'h030]); end
  endtask

  task automatic test_starve();
    int n_dm;
    bit found;
    do_reset();
    bus.if_req = 1; bus.if_addr = 14'h040;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 14'h050;
    n_dm = 0; found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      smp();
      if (bus.dm_ack === 1'b1) n_dm++;
      if (bus.if_ack === 1'b1) begin
        found = 1;
        checks++; if (dut.starve_cnt !== 3'd0) begin errors++; $display("FAIL starve_clear got=%0d exp=0", dut.starve_cnt); end
        checks++; if (bus.if_rdata !== pat(14'h040)) begin errors++; $display("FAIL starve_data got=%h exp=%h", bus.if_rdata, pat(14'h040)); end
      end
      tick();
    end
    clear_reqs();
    checks++; if (!found) begin errors++; $display("FAIL starve_timeout got=no if_ack exp=if_ack"); end
    checks++; if (n_dm != 4) begin errors++; $display("FAIL starve_losses got=%0d exp=4", n_dm); end
    repeat (4) tick();
  endtask

  task automatic test_rdlat2();
    int en_cyc, ack_cyc, n_ack;
    do_reset();
    bus2.dm_req = 1; bus2.dm_we = 0; bus2.dm_addr = 14'h005;
    en_cyc = -1; ack_cyc = -1; n_ack = 0;
    for (int c = 1; c <= 12; c++) begin
      smp();
      if (bus2.mem_en === 1'b1 && en_cyc < 0) en_cyc = c;
      if (bus2.dm_ack === 1'b1) begin
        n_ack++;
        if (ack_cyc < 0) begin
          ack_cyc = c;
          checks++; if (bus2.dm_rdata !== pat(14'h005)) begin errors++; $display("FAIL rdlat2_data got=%h exp=%h", bus2.dm_rdata, pat(14'h005)); end
        end
      end
      tick();
      if (ack_cyc > 0) bus2.dm_req = 0;
    end
    checks++; if (en_cyc != 2) begin errors++; $display("FAIL rdlat2_en_cycle got=%0d exp=2", en_cyc); end
    checks++; if (ack_cyc != 4) begin errors++; $display("FAIL rdlat2_ack_cycle got=%0d exp=4", ack_cyc); end
    checks++; if (n_ack != 1) begin errors++; $display("FAIL rdlat2_ack_count got=%0d exp=1", n_ack); end
  endtask

  task automatic test_reset_abort();
    int n_ack, ack_cyc;
    do_reset();
    bus.if_req = 1; bus.if_addr = 14'h060;
    smp();
    tick(); smp();
    checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL abort_issue got=%b exp=1", bus.mem_en); end
    tick(); reset = 0; smp();
    n_ack = (bus.if_ack === 1'b1) ? 1 : 0;
    tick(); reset = 1; bus.if_req = 0; smp();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    for (int c = 0; c < 4; c++) begin
      if (bus.if_ack === 1'b1) n_ack++;
      tick(); smp();
    end
    checks++; if (n_ack != 0) begin errors++; $display("FAIL abort_ack got=%0d acks exp=0", n_ack); end
    tick();
    bus.if_req = 1; bus.if_addr = 14'h061;
    ack_cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      smp();
      if (bus.if_ack === 1'b1 && ack_cyc < 0) begin
        ack_cyc = c;
        checks++; if (bus.if_rdata !== pat(14'h061)) begin errors++; $display("FAIL abort_new_data got=%h exp=%h", bus.if_rdata, pat(14'h061)); end
      end
      tick();
      if (ack_cyc > 0) bus.if_req = 0;
    end
    checks++; if (ack_cyc != 3) begin errors++; $display("FAIL abort_new_cycle got=%0d exp=3", ack_cyc); end
  endtask

  task automatic test_dm_drop();
    int n_dm, if_cyc;
    do_reset();
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 14'h070; bus.dm_wdata = 32'h77;
    bus.if_req = 1; bus.if_addr = 14'h011;
    n_dm = 0; if_cyc = -1;
    smp();
    tick(); bus.dm_req = 0; smp();
    checks++; if (bus.dm_ack !== 1'b1 || bus.if_ack !== 1'b0) begin errors++; $display("FAIL drop_c2 got dm=%b if=%b exp 1 0", bus.dm_ack, bus.if_ack); end
    if (bus.dm_ack === 1'b1) n_dm++;
    for (int c = 3; c <= 10; c++) begin
      tick();
      if (if_cyc > 0) bus.if_req = 0;
      smp();
      if (bus.dm_ack === 1'b1) n_dm++;
      if (bus.if_ack === 1'b1 && if_cyc < 0) if_cyc = c;
    end
    clear_reqs();
    checks++; if (n_dm != 1) begin errors++; $display("FAIL drop_dm_acks got=%0d exp=1", n_dm); end
    checks++; if (ram[14'h070] !== 32'h77) begin errors++; $display("FAIL drop_mem got=%h exp=77", ram[14'h070]); end
    checks++; if (if_cyc != 5) begin errors++; $display("FAIL drop_if_cycle got=%0d exp=5", if_cyc); end
    checks++; if (bus.if_rdata !== pat(14'h011)) begin errors++; $display("FAIL drop_if_data got=%h exp=%h", bus.if_rdata, pat(14'h011)); end
  endtask

  // Transaction-level model: a granted transfer occupies the port for one
  // cycle (write) or 1+RD_LAT cycles (read) after the idle cycle in which it
  // won; ifetch outranks dmem after 4 consecutive lost arbitrations.
  task automatic test_random();
    logic [31:0] mdl [0:15];
    logic        pend [3];
    logic [13:0] a [3];
    logic [31:0] d [3];
    logic        w [3];
    logic        exp_ack [3];
    int          lost, rem, win;
    logic [13:0] t_a;
    logic [31:0] t_d;
    logic        t_w;
    logic [31:0] last_if, last_dm;
    logic        exp_busy;
    do_reset();
    for (int i = 0; i < 16; i++) mdl[i] = pat(14'(i));
    for (int r = 0; r < 3; r++) begin
      pend[r] = 0; a[r] = '0; d[r] = '0; w[r] = 0; exp_ack[r] = 0;
    end
    lost = 0; rem = 0; win = 0; t_a = '0; t_d = '0; t_w = 0;
    last_if = '0; last_dm = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc != 0) tick();
      for (int r = 0; r < 3; r++) begin
        if (exp_ack[r]) pend[r] = 0;
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1;
          a[r] = 14'($urandom_range(0, 15));
          d[r] = $urandom;
          w[r] = (r == 0) ? 1'b1 : (r == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
      bus.ld_req = pend[0]; bus.ld_addr = a[0]; bus.ld_wdata = d[0];
      bus.dm_req = pend[1]; bus.dm_we = w[1]; bus.dm_addr = a[1]; bus.dm_wdata = d[1];
      bus.if_req = pend[2]; bus.if_addr = a[2];
      smp();
      for (int r = 0; r < 3; r++) exp_ack[r] = 0;
      if (rem == 0) begin
        exp_busy = 0;
        if (pend[0] || pend[1] || pend[2]) begin
          if (pend[0]) win = 0;
          else if (pend[2] && (lost >= 4 || !pend[1])) win = 2;
          else win = 1;
          if (win == 2) lost = 0;
          else if (pend[2] && lost < 4) lost++;
          t_a = a[win]; t_d = d[win]; t_w = w[win];
          rem = t_w ? 1 : 2;
        end
      end else begin
        exp_busy = 1;
        rem--;
        if (rem == 0) begin
          exp_ack[win] = 1;
          if (t_w) mdl[t_a[3:0]] = t_d;
          else if (win == 2) last_if = mdl[t_a[3:0]];
          else last_dm = mdl[t_a[3:0]];
        end
      end
      checks++; if ({bus.ld_ack, bus.dm_ack, bus.if_ack} !== {exp_ack[0], exp_ack[1], exp_ack[2]}) begin errors++; $display("FAIL rand_acks cyc=%0d got=%b exp=%b", cyc, {bus.ld_ack, bus.dm_ack, bus.if_ack}, {exp_ack[0], exp_ack[1], exp_ack[2]}); end
      checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_busy); end
      checks++; if (bus.if_rdata !== last_if || bus.dm_rdata !== last_dm) begin errors++; $display("FAIL rand_rdata cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.if_rdata, bus.dm_rdata, last_if, last_dm); end
    end
    tick();
    clear_reqs();
    repeat (4) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 0;
    clear_reqs();
    test_reset();
    test_if_read();
    test_ld_dm_simul();
    test_starve();
    test_rdlat2();
    test_reset_abort();
    test_dm_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port instruction/data block RAM between three requesters: the UART program loader, the data-memory stage (dmem) and instruction fetch (ifetch).
- Fixed priority loader > dmem > ifetch, with a starvation guard for ifetch.
- Sits between the CPU core/loader and the memory macro inside top.
- Each requester uses a req/ack handshake; the CPU stalls on a request until its ack arrives.

Parameters:
- ADDR_W, 14, word address width.
- DATA_W, 32, data width.
- RD_LAT, 1, memory read latency in cycles (>=1).
- STARVE_MAX, 4, consecutive lost ifetch arbitrations before ifetch outranks dmem.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- if_req  in  1  ifetch read request.
- if_addr  in  ADDR_W  ifetch word address.
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle.
- if_rdata  out  DATA_W  fetched word.
- dm_req  in  1  dmem request.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  dmem address.
- dm_wdata  in  DATA_W  dmem write data.
- dm_ack  out  1  one-cycle completion pulse.
- dm_rdata  out  DATA_W  dmem read data, valid with dm_ack.
- ld_req  in  1  loader write request (write-only).
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader data.
- ld_ack  out  1  one-cycle completion pulse.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, RD_LAT cycles after the enable.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, starve_cnt=0. All acks, mem_en, mem_we and busy are 0. mem_addr, mem_wdata and the rdata outputs are 0.
- Reset mid-transaction aborts it; no ack is ever emitted for an aborted transaction.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any req is high, select the winner. mem_addr, mem_wdata, mem_we and the winner id are registered on this edge. Next state is ISSUE. With no req, stay in IDLE.
- Priority order: ld_req, then dm_req, then if_req.
- Starvation guard: if starve_cnt >= STARVE_MAX and if_req is high, ifetch beats dmem. It never beats the loader.
- starve_cnt: increments (saturating at STARVE_MAX) on each IDLE arbitration where if_req is high and ifetch loses. It clears when ifetch is granted.
- mem_we source: forced 1 for the loader, dm_we for dmem, forced 0 for ifetch.
- ISSUE: mem_en=1 for exactly this cycle.
  - Write: the winner's ack pulses this cycle, then the FSM returns to IDLE. A write costs 2 cycles from IDLE.
  - Read: load a latency counter with RD_LAT-1, then go to WAIT.
- WAIT: decrement the counter each cycle.
  - At 0: the winner's ack=1 and its rdata output is driven from mem_rdata. The ack lands exactly RD_LAT cycles after the ISSUE cycle.
  - Then return to IDLE. A read costs 2+RD_LAT cycles, i.e. 3 cycles at RD_LAT=1.
- rdata outputs hold their last delivered value between acks.
- Requesters must hold req, addr and wdata stable from assertion until their ack.
- Transaction completion: once granted, a transaction completes with an ack even if req drops afterwards. A req dropped before grant is ignored.
- Back-to-back requests: the cycle after an ack is IDLE, so a requester's req being high in its own ack cycle does not cause a double grant. Arbitration only occurs in IDLE.
- Simultaneous requests: exactly one ack per transaction, and only to the registered winner. Losers keep waiting.
- Address and data are passed unmodified; no width arithmetic other than the counters.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2);
  - requester id constants (ID_LD, ID_DM, ID_IF).
- One natural sub-module: arb_priority_sel. It is combinational and returns the winner id from the three reqs plus the starvation flag.
- The FSM, counters and registered memory signals stay in mem_port_arbiter.

Test Plan:
- Reset, then if_req=1, if_addr=0x010, mem returns 0xDEADBEEF:
  - mem_en high in cycle 2 with mem_we=0 and mem_addr=0x010;
  - if_ack pulses in cycle 3 with if_rdata=0xDEADBEEF.
- Simultaneous ld_req (addr 0x020, wdata 0x11) and dm_req (write, addr 0x030, wdata 0x22):
  - loader granted first, ld_ack at cycle 2;
  - dm_ack 2 cycles later;
  - memory contents at 0x020=0x11 and 0x030=0x22.
- if_req and dm_req both held continuously (dmem reads), STARVE_MAX=4: ifetch is granted after exactly 4 lost arbitrations, and starve_cnt then returns to 0.
- RD_LAT=2 build, dm read of 0x005: ack arrives exactly 2 cycles after the mem_en cycle, with a total of 4 cycles from req.
- Assert reset=0 during WAIT of an ifetch read:
  - the next cycle shows IDLE with busy=0;
  - no if_ack is ever pulsed for that read;
  - a new if_req after reset release completes normally.
- dm_req dropped one cycle after grant (write):
  - write still occurs and dm_ack still pulses once;
  - a pending if_req is granted next.
